output_process_block: RTL and testbench

Receive side of the router's input slicing: rejoins a 7-bit address and a 4-bit (Hamming-decoded) data word into one 11-bit packet. Routes the packet to one of three output ports (local core or two neighbour links) under a 2-bit select channel. Sits between the switch/decoder stage and the output links, and is the inverse of the merge-then-slice path on the input side. Clocked, with valid/ready handshakes on every channel.

---
 rtl/opb_pkg.sv | 31 +++
 rtl/output_process_block_join_slot.sv | 46 ++++
 rtl/output_process_block.sv | 163 ++++++++++++++++
 tb/tb_output_process_block.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/opb_pkg.sv
// opb_pkg: shared constants and types for output_process_block.
//   DATA_W / ADDR_W / PKT_W : field and packet widths (PKT_W = ADDR_W + DATA_W)
//   DROP_CNT_W               : width of the saturating drop counter
//   pkt_t                    : packed packet {addr, data}, addr in the upper bits
//   state_t                  : block FSM states
//   sel_t                    : route-select encodings
package opb_pkg;

  localparam int DATA_W     = 4;
  localparam int ADDR_W     = 7;
  localparam int PKT_W      = ADDR_W + DATA_W;
  localparam int DROP_CNT_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_OUT0    = 2'd0,
    SEL_OUT1    = 2'd1,
    SEL_OUT2    = 2'd2,
    SEL_ILLEGAL = 2'd3
  } sel_t;

endpackage

// File: rtl/output_process_block_join_slot.sv
// join_slot: one-entry holding register with a full flag.
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : slot may accept (block is collecting)
//   clear             : empty the slot at the next edge
//   in_valid/in_ready : input handshake; in_ready = enable && !full
//   in_data           : beat payload
//   accept            : in_valid && in_ready this cycle
//   full              : slot holds a beat
//   held              : stored beat
module join_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             accept,
  output logic             full,
  output logic [WIDTH-1:0] held
);

  logic             full_reg;
  logic [WIDTH-1:0] held_reg;

  // A full slot never takes a second beat; the sender keeps holding it.
  assign in_ready = enable && !full_reg;
  assign accept   = in_valid && in_ready;
  assign full     = full_reg;
  assign held     = held_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      held_reg <= '0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (accept) begin
      full_reg <= 1'b1;
      held_reg <= in_data;
    end
  end

endmodule

// File: rtl/output_process_block.sv
// output_process_block: joins an address beat, a data beat and a route-select
// beat into one packet and routes it to one of three output ports.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   data_valid/data_ready/data : data field channel
//   addr_valid/addr_ready/addr : address field channel
//   sel_valid/sel_ready/sel    : route select (0..2 = port, 3 = drop)
//   outN_valid/outN_ready      : output port N handshake, N = 0..2
//   outN_pkt                   : held packet {addr, data}, same on every port
//   drop_pulse                 : one-cycle pulse when a sel==3 packet is dropped
//   drop_count                 : saturating count of dropped packets
module output_process_block
  import opb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DATA_W-1:0]     data,
  input  logic                  addr_valid,
  output logic                  addr_ready,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  input  logic [1:0]            sel,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [PKT_W-1:0]      out0_pkt,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [PKT_W-1:0]      out1_pkt,
  output logic                  out2_valid,
  input  logic                  out2_ready,
  output logic [PKT_W-1:0]      out2_pkt,
  output logic                  drop_pulse,
  output logic [DROP_CNT_W-1:0] drop_count
);

  state_t                  state_reg, state_next;
  logic [DROP_CNT_W-1:0]   drop_count_reg;
  logic                    collecting;
  logic                    clear_slots;
  logic                    data_accept, addr_accept, sel_accept;
  logic                    data_full, addr_full, sel_full;
  logic [DATA_W-1:0]       data_held;
  logic [ADDR_W-1:0]       addr_held;
  logic [1:0]              sel_held;
  logic                    all_set;
  logic [2:0]              out_valid_vec;
  logic [2:0]              out_ready_vec;
  pkt_t                    held_pkt;

  // Readies are forced low while reset is held, even though the slots
  // already read empty.
  assign collecting = rst_n && (state_reg == COLLECT);

  join_slot #(.WIDTH(DATA_W)) u_data_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (collecting),
    .clear    (clear_slots),
    .in_valid (data_valid),
    .in_ready (data_ready),
    .in_data  (data),
    .accept   (data_accept),
    .full     (data_full),
    .held     (data_held)
  );

  join_slot #(.WIDTH(ADDR_W)) u_addr_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (collecting),
    .clear    (clear_slots),
    .in_valid (addr_valid),
    .in_ready (addr_ready),
    .in_data  (addr),
    .accept   (addr_accept),
    .full     (addr_full),
    .held     (addr_held)
  );

  join_slot #(.WIDTH(2)) u_sel_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (collecting),
    .clear    (clear_slots),
    .in_valid (sel_valid),
    .in_ready (sel_ready),
    .in_data  (sel),
    .accept   (sel_accept),
    .full     (sel_full),
    .held     (sel_held)
  );

  // Counts beats landing this edge so the last beat moves straight to SEND.
  assign all_set = (data_full || data_accept) &&
                   (addr_full || addr_accept) &&
                   (sel_full  || sel_accept);

  assign held_pkt.addr = addr_held;
  assign held_pkt.data = data_held;

  assign out_ready_vec = {out2_ready, out1_ready, out0_ready};

  // Output demux: the held select picks exactly one port; sel==3 picks none.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_port_valid
      assign out_valid_vec[gi] = (state_reg == SEND) && (sel_held == 2'(gi));
    end
  endgenerate

  assign out0_valid = out_valid_vec[0];
  assign out1_valid = out_valid_vec[1];
  assign out2_valid = out_valid_vec[2];
  assign out0_pkt   = held_pkt;
  assign out1_pkt   = held_pkt;
  assign out2_pkt   = held_pkt;
  assign drop_count = drop_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    clear_slots = 1'b0;
    drop_pulse  = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (all_set) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (sel_held == SEL_ILLEGAL) begin
          // Illegal route: discard after a single SEND cycle.
          drop_pulse  = 1'b1;
          clear_slots = 1'b1;
          state_next  = COLLECT;
        end else if (out_ready_vec[sel_held]) begin
          clear_slots = 1'b1;
          state_next  = COLLECT;
        end
      end
      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_reg <= '0;
    end else if (drop_pulse && (drop_count_reg != {DROP_CNT_W{1'b1}})) begin
      drop_count_reg <= drop_count_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_output_process_block.sv
module tb_output_process_block;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_valid, addr_valid, sel_valid;
  logic        data_ready, addr_ready, sel_ready;
  logic [3:0]  data;
  logic [6:0]  addr;
  logic [1:0]  sel;
  logic        out0_valid, out1_valid, out2_valid;
  logic        out0_ready, out1_ready, out2_ready;
  logic [10:0] out0_pkt, out1_pkt, out2_pkt;
  logic        drop_pulse;
  logic [7:0]  drop_count;

  int tests    = 0;
  int failures = 0;
  int exp_drops = 0;

  output_process_block dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data       (data),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel        (sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_pkt   (out0_pkt),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_pkt   (out1_pkt),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2_pkt   (out2_pkt),
    .drop_pulse (drop_pulse),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d;
    logic [6:0]  a;
    logic [1:0]  s;
    logic [10:0] exp_pkt;
    logic [2:0]  exp_valid;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [2:0] ov();
    return {out2_valid, out1_valid, out0_valid};
  endfunction

  function automatic logic [2:0] rdys();
    return {sel_ready, addr_ready, data_ready};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers all three beats together from an empty COLLECT state and checks
  // the SEND cycle and the return to COLLECT. The selected port must be ready.
  task automatic send_packet(input logic [3:0] d, input logic [6:0] a, input logic [1:0] s,
                             input logic [10:0] exp_pkt, input logic [2:0] exp_v,
                             input string tag);
    logic [10:0] got;
    check({tag, " ready_in"}, rdys(), 3'b111);
    data = d; addr = a; sel = s;
    data_valid = 1'b1; addr_valid = 1'b1; sel_valid = 1'b1;
    tick();
    data_valid = 1'b0; addr_valid = 1'b0; sel_valid = 1'b0;
    check({tag, " valid"}, ov(), exp_v);
    check({tag, " drop_pulse"}, drop_pulse, (s == 2'd3));
    check({tag, " ready_send"}, rdys(), 3'b000);
    got = (s == 2'd0) ? out0_pkt : (s == 2'd1) ? out1_pkt : out2_pkt;
    if (s != 2'd3) check({tag, " pkt"}, got, exp_pkt);
    if (s == 2'd3 && exp_drops != 255) exp_drops++;
    tick();
    check({tag, " valid_after"}, ov(), 3'b000);
    check({tag, " pulse_after"}, drop_pulse, 1'b0);
    check({tag, " ready_after"}, rdys(), 3'b111);
    check({tag, " drop_count"}, drop_count, exp_drops);
    $display("[TB] %s addr=%02h data=%01h sel=%0d pkt=%03h drops=%0d",
             tag, a, d, s, got, drop_count);
  endtask

  initial begin
    vecs[0] = '{d: 4'hA, a: 7'h55, s: 2'd1, exp_pkt: 11'h55A, exp_valid: 3'b010};
    vecs[1] = '{d: 4'hF, a: 7'h01, s: 2'd2, exp_pkt: 11'h01F, exp_valid: 3'b100};
    vecs[2] = '{d: 4'h0, a: 7'h00, s: 2'd0, exp_pkt: 11'h000, exp_valid: 3'b001};
    vecs[3] = '{d: 4'h3, a: 7'h7F, s: 2'd0, exp_pkt: 11'h7F3, exp_valid: 3'b001};
    vecs[4] = '{d: 4'h5, a: 7'h2A, s: 2'd3, exp_pkt: 11'h2A5, exp_valid: 3'b000};
    vecs[5] = '{d: 4'hC, a: 7'h40, s: 2'd2, exp_pkt: 11'h40C, exp_valid: 3'b100};

    rst_n = 1'b0;
    data_valid = 1'b0; addr_valid = 1'b0; sel_valid = 1'b0;
    data = '0; addr = '0; sel = '0;
    out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;

    // Reset state, including readies held low with valids offered.
    #1;
    data_valid = 1'b1; addr_valid = 1'b1; sel_valid = 1'b1;
    tick();
    check("reset ready", rdys(), 3'b000);
    check("reset valid", ov(), 3'b000);
    check("reset pulse", drop_pulse, 1'b0);
    check("reset count", drop_count, 8'd0);
    tick();
    check("reset ready2", rdys(), 3'b000);
    data_valid = 1'b0; addr_valid = 1'b0; sel_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("release ready", rdys(), 3'b111);

    // Reset mid-SEND with the sink stalled.
    out1_ready = 1'b0;
    data = 4'h9; addr = 7'h33; sel = 2'd1;
    data_valid = 1'b1; addr_valid = 1'b1; sel_valid = 1'b1;
    tick();
    data_valid = 1'b0; addr_valid = 1'b0; sel_valid = 1'b0;
    check("midsend valid", ov(), 3'b010);
    #2 rst_n = 1'b0;
    #1;
    check("midsend reset valid", ov(), 3'b000);
    check("midsend reset ready", rdys(), 3'b000);
    check("midsend reset count", drop_count, 8'd0);
    check("midsend reset pulse", drop_pulse, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    out1_ready = 1'b1;
    #1;
    send_packet(4'h6, 7'h21, 2'd1, 11'h216, 3'b010, "post_reset");

    // Skewed beats: sel first, data 5 cycles later, addr 3 cycles after.
    sel = 2'd2; sel_valid = 1'b1;
    check("skew sel_ready", sel_ready, 1'b1);
    tick();
    sel = 2'd3;
    check("skew full sel_ready", sel_ready, 1'b0);
    check("skew data_ready", data_ready, 1'b1);
    tick();
    sel_valid = 1'b0;
    tick(); tick(); tick();
    check("skew no valid", ov(), 3'b000);
    data = 4'hF; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("skew full data_ready", data_ready, 1'b0);
    tick(); tick();
    addr = 7'h01; addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
    check("skew valid", ov(), 3'b100);
    check("skew pkt", out2_pkt, 11'h01F);
    tick();
    check("skew ready_after", rdys(), 3'b111);
    check("skew valid_after", ov(), 3'b000);
    $display("[TB] skew addr=01 data=f sel=2 pkt=%03h", 11'h01F);

    // Backpressure on out0 for 10 cycles.
    out0_ready = 1'b0;
    data = 4'h3; addr = 7'h12; sel = 2'd0;
    data_valid = 1'b1; addr_valid = 1'b1; sel_valid = 1'b1;
    tick();
    data_valid = 1'b0; addr_valid = 1'b0; sel_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp valid", ov(), 3'b001);
      check("bp pkt", out0_pkt, 11'h123);
      check("bp ready", rdys(), 3'b000);
      tick();
    end
    out0_ready = 1'b1;
    check("bp valid11", ov(), 3'b001);
    tick();
    check("bp valid_after", ov(), 3'b000);
    check("bp ready_after", rdys(), 3'b111);
    $display("[TB] backpressure addr=12 data=3 sel=0 pkt=%03h", 11'h123);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      send_packet(vecs[i].d, vecs[i].a, vecs[i].s, vecs[i].exp_pkt, vecs[i].exp_valid,
                  $sformatf("vec%0d", i));
    end

    // Back-to-back random packets to legal ports.
    for (int i = 0; i < 20; i++) begin
      logic [3:0] rd;
      logic [6:0] ra;
      logic [1:0] rs;
      rd = 4'($urandom_range(0, 15));
      ra = 7'($urandom_range(0, 127));
      rs = 2'($urandom_range(0, 2));
      send_packet(rd, ra, rs, {ra, rd}, 3'b001 << rs, $sformatf("b2b%0d", i));
    end

    // Drop counter saturation.
    for (int i = 0; i < 256; i++) begin
      logic [3:0] rd;
      logic [6:0] ra;
      rd = 4'($urandom_range(0, 15));
      ra = 7'($urandom_range(0, 127));
      send_packet(rd, ra, 2'd3, {ra, rd}, 3'b000, $sformatf("drop%0d", i));
    end
    check("drop saturated", drop_count, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
